// File: rtl/gte3_refclk_ctrl_pkg.sv
// Shared types and helpers for the GTE3 refclk sequencer and monitor.
package gte3_refclk_ctrl_pkg;

    // Sequencer states; this encoding is exported on STATE for debug.
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STARTUP = 3'd1,
        ST_MEASURE = 3'd2,
        ST_CHECK   = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_RETRY   = 3'd5,
        ST_FAULT   = 3'd6
    } refclk_state_t;

    // Number of bits needed to hold the values 0..value-1, never less than 1.
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/gte3_refclk_edge_sync.sv
// Brings the buffer's ODIV2 output into the system clock domain and turns
// each rising edge into a one-cycle pulse. The pulse is registered, so a
// rising edge sampled by the first flop reaches the counter three cycles later.
module gte3_refclk_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync_meta;
    logic sync_stable;
    logic sync_prev;

    // Two-flop synchronizer, a history flop and a registered rising-edge pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            sync_prev   <= 1'b0;
            edge_pulse  <= 1'b0;
        end else begin
            sync_meta   <= async_in;
            sync_stable <= sync_meta;
            sync_prev   <= sync_stable;
            edge_pulse  <= sync_stable & ~sync_prev;
        end
    end

endmodule

// File: rtl/gte3_refclk_ctrl.sv
// Sequencer and frequency monitor for a GTE3 differential refclk buffer.
// Enables the buffer, waits for it to settle, counts ODIV2 edges over fixed
// windows and reports READY while the count stays in range. Failed attempts
// power-cycle the buffer; too many failures latch a sticky FAULT.
module gte3_refclk_ctrl
    import gte3_refclk_ctrl_pkg::*;
#(
    parameter int STARTUP_CYCLES = 1024,
    parameter int WINDOW_CYCLES  = 4096,
    parameter int CNT_W          = 16,
    parameter int CNT_MIN        = 1000,
    parameter int CNT_MAX        = 1100,
    parameter int OFF_CYCLES     = 256,
    parameter int MAX_RETRY      = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             ODIV2,
    output logic             CEB,
    output logic             READY,
    output logic             FAULT,
    output logic [CNT_W-1:0] FREQ_COUNT,
    output logic [2:0]       STATE
);

    // One down-counter is shared by the startup wait, the window and the off time.
    localparam int LOAD_MAX_A = (STARTUP_CYCLES > WINDOW_CYCLES) ? STARTUP_CYCLES : WINDOW_CYCLES;
    localparam int LOAD_MAX   = (LOAD_MAX_A > OFF_CYCLES) ? LOAD_MAX_A : OFF_CYCLES;
    localparam int TIMER_W    = clog2(LOAD_MAX);
    localparam int RETRY_W    = clog2(MAX_RETRY + 1);

    localparam logic [TIMER_W-1:0] T_STARTUP = TIMER_W'(STARTUP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_WINDOW  = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_OFF     = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_LO    = CNT_W'(CNT_MIN);
    localparam logic [CNT_W-1:0]   CNT_HI    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]   CNT_SAT   = '1;
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    refclk_state_t       state;
    logic [TIMER_W-1:0]  timer;
    logic [CNT_W-1:0]    edge_cnt;
    logic [CNT_W-1:0]    edge_cnt_inc;
    logic [CNT_W-1:0]    edge_restart;
    logic [RETRY_W-1:0]  retry_cnt;
    logic                edge_pulse;
    logic                timer_done;

    gte3_refclk_edge_sync u_edge_sync (
        .clock      (CLK),
        .reset      (RST),
        .async_in   (ODIV2),
        .edge_pulse (edge_pulse)
    );

    assign timer_done   = (timer == '0);
    assign edge_restart = {{(CNT_W-1){1'b0}}, edge_pulse};
    assign STATE        = state;

    // Saturating edge count; the window-end compare sees the clamped value.
    always_comb begin
        edge_cnt_inc = edge_cnt;
        if (edge_pulse && (edge_cnt != CNT_SAT)) begin
            edge_cnt_inc = edge_cnt + 1'b1;
        end
    end

    function automatic logic in_range(input logic [CNT_W-1:0] count);
        return (count >= CNT_LO) && (count <= CNT_HI);
    endfunction

    // Sequencer: EN low aborts to OFF ahead of any window end, and the retry
    // budget decides between another power cycle and the sticky fault.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_OFF;
            CEB        <= 1'b1;
            READY      <= 1'b0;
            FAULT      <= 1'b0;
            FREQ_COUNT <= '0;
            timer      <= '0;
            edge_cnt   <= '0;
            retry_cnt  <= '0;
        end else if (!EN) begin
            state     <= ST_OFF;
            CEB       <= 1'b1;
            READY     <= 1'b0;
            FAULT     <= 1'b0;
            timer     <= '0;
            edge_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state <= ST_STARTUP;
                    CEB   <= 1'b0;
                    timer <= T_STARTUP;
                end
                ST_STARTUP: begin
                    if (timer_done) begin
                        state    <= ST_MEASURE;
                        timer    <= T_WINDOW;
                        edge_cnt <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (timer_done) begin
                        state      <= ST_CHECK;
                        FREQ_COUNT <= edge_cnt;
                        edge_cnt   <= edge_restart;
                        timer      <= T_WINDOW;
                    end else begin
                        edge_cnt <= edge_cnt_inc;
                        timer    <= timer - 1'b1;
                    end
                end
                ST_CHECK: begin
                    edge_cnt <= edge_cnt_inc;
                    timer    <= timer - 1'b1;
                    if (in_range(FREQ_COUNT)) begin
                        state     <= ST_LOCKED;
                        READY     <= 1'b1;
                        retry_cnt <= '0;
                    end else if (retry_cnt == RETRY_LIM) begin
                        state <= ST_FAULT;
                        CEB   <= 1'b1;
                        FAULT <= 1'b1;
                    end else begin
                        state     <= ST_RETRY;
                        CEB       <= 1'b1;
                        retry_cnt <= retry_cnt + 1'b1;
                        timer     <= T_OFF;
                    end
                end
                ST_LOCKED: begin
                    if (timer_done) begin
                        FREQ_COUNT <= edge_cnt;
                        edge_cnt   <= edge_restart;
                        timer      <= T_WINDOW;
                        if (!in_range(edge_cnt)) begin
                            READY <= 1'b0;
                            CEB   <= 1'b1;
                            if (retry_cnt == RETRY_LIM) begin
                                state <= ST_FAULT;
                                FAULT <= 1'b1;
                            end else begin
                                state     <= ST_RETRY;
                                retry_cnt <= retry_cnt + 1'b1;
                                timer     <= T_OFF;
                            end
                        end
                    end else begin
                        edge_cnt <= edge_cnt_inc;
                        timer    <= timer - 1'b1;
                    end
                end
                ST_RETRY: begin
                    if (timer_done) begin
                        state <= ST_STARTUP;
                        CEB   <= 1'b0;
                        timer <= T_STARTUP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_FAULT: begin
                    CEB   <= 1'b1;
                    FAULT <= 1'b1;
                end
                default: begin
                    state <= ST_OFF;
                    CEB   <= 1'b1;
                    READY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gte3_refclk_ctrl.sv
// Directed bench for the refclk sequencer with a timeline-based reference model.
module tb_gte3_refclk_ctrl;

    localparam int STARTUP   = 8;
    localparam int WINDOW    = 64;
    localparam int CNT_W     = 16;
    localparam int CNT_MIN   = 14;
    localparam int CNT_MAX   = 18;
    localparam int OFF       = 4;
    localparam int MAX_RETRY = 2;
    localparam int MAXCYC    = 8192;
    localparam int SAT       = (1 << CNT_W) - 1;

    logic             CLK;
    logic             RST;
    logic             EN;
    logic             ODIV2;
    logic             CEB;
    logic             READY;
    logic             FAULT;
    logic [CNT_W-1:0] FREQ_COUNT;
    logic [2:0]       STATE;

    int odiv_half     = 20;
    int checks_total  = 0;
    int checks_passed = 0;

    gte3_refclk_ctrl #(
        .STARTUP_CYCLES (STARTUP),
        .WINDOW_CYCLES  (WINDOW),
        .CNT_W          (CNT_W),
        .CNT_MIN        (CNT_MIN),
        .CNT_MAX        (CNT_MAX),
        .OFF_CYCLES     (OFF),
        .MAX_RETRY      (MAX_RETRY)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .ODIV2      (ODIV2),
        .CEB        (CEB),
        .READY      (READY),
        .FAULT      (FAULT),
        .FREQ_COUNT (FREQ_COUNT),
        .STATE      (STATE)
    );

    // System clock, period 10; rising edges fall on odd multiples of 5.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Refclk divider output; toggles only on multiples of 10, never on a CLK edge.
    initial begin
        ODIV2 = 1'b0;
        forever begin
            if (odiv_half == 0) begin
                ODIV2 = 1'b0;
                #10;
            end else begin
                #(odiv_half) ODIV2 = ~ODIV2;
            end
        end
    end

    // Reference model: ODIV2 samples per cycle, windows as absolute cycle spans.
    bit samp [0:MAXCYC-1];
    int cyc        = 0;
    int m_state    = 0;
    int m_ceb      = 1;
    int m_ready    = 0;
    int m_fault    = 0;
    int m_freq     = 0;
    int m_retry    = 0;
    int m_deadline = 0;
    int m_win      = 0;

    // A rise sampled at cycle k is counted at cycle k+3.
    function automatic int edgeAt(input int m);
        if (m < 4 || m >= MAXCYC) return 0;
        return (samp[m-3] && !samp[m-4]) ? 1 : 0;
    endfunction

    function automatic int windowCount(input int first, input int last);
        int total;
        total = 0;
        for (int m = first; m <= last; m++) total += edgeAt(m);
        return (total > SAT) ? SAT : total;
    endfunction

    function automatic bit inRange(input int count);
        return (count >= CNT_MIN) && (count <= CNT_MAX);
    endfunction

    task automatic modelFailAttempt();
        m_ceb = 1;
        if (m_retry == MAX_RETRY) begin
            m_state = 6;
            m_fault = 1;
        end else begin
            m_retry++;
            m_state    = 5;
            m_deadline = cyc + OFF;
        end
    endtask

    always @(posedge CLK) begin
        if (cyc < MAXCYC) samp[cyc] = !RST && (ODIV2 === 1'b1);
        if (RST) begin
            if (cyc >= 1) samp[cyc-1] = 1'b0;
            if (cyc >= 2) samp[cyc-2] = 1'b0;
            m_state = 0; m_ceb = 1; m_ready = 0; m_fault = 0; m_freq = 0; m_retry = 0;
        end else if (!EN) begin
            m_state = 0; m_ceb = 1; m_ready = 0; m_fault = 0; m_retry = 0;
        end else begin
            case (m_state)
                0: begin m_state = 1; m_ceb = 0; m_deadline = cyc + STARTUP; end
                1: if (cyc == m_deadline) begin
                       m_state = 2; m_win = cyc + 1; m_deadline = cyc + WINDOW;
                   end
                2: if (cyc == m_deadline) begin
                       m_freq = windowCount(m_win, cyc - 1);
                       m_win = cyc; m_deadline = cyc + WINDOW; m_state = 3;
                   end
                3: if (inRange(m_freq)) begin
                       m_state = 4; m_ready = 1; m_retry = 0;
                   end else begin
                       modelFailAttempt();
                   end
                4: if (cyc == m_deadline) begin
                       m_freq = windowCount(m_win, cyc - 1);
                       m_win = cyc; m_deadline = cyc + WINDOW;
                       if (!inRange(m_freq)) begin
                           m_ready = 0;
                           modelFailAttempt();
                       end
                   end
                5: if (cyc == m_deadline) begin
                       m_state = 1; m_ceb = 0; m_deadline = cyc + STARTUP;
                   end
                default: ;
            endcase
        end
        cyc++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks_total++;
        if (actual >= lo && actual <= hi) checks_passed++;
        else $display("[TB] FAIL %s at %0t: got %0d, expected %0d..%0d", name, $time, actual, lo, hi);
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input int half);
        RST       = rst;
        EN        = en;
        odiv_half = half;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic waitForState(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (int'(STATE) != target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checkOutput(name, int'(STATE), target);
    endtask

    // Every cycle, all outputs against the model.
    always @(negedge CLK) begin
        checkOutput("model_ceb",   int'(CEB),        m_ceb);
        checkOutput("model_ready", int'(READY),      m_ready);
        checkOutput("model_fault", int'(FAULT),      m_fault);
        checkOutput("model_state", int'(STATE),      m_state);
        checkOutput("model_freq",  int'(FREQ_COUNT), m_freq);
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int  attempts;
        int  ceb_high;
        int  n;
        bit  ready_seen;

        // Reset values
        applyStimulus(1'b1, 1'b0, 20);
        waitCycles(3);
        checkOutput("rst_ceb",   int'(CEB), 1);
        checkOutput("rst_ready", int'(READY), 0);
        checkOutput("rst_fault", int'(FAULT), 0);
        checkOutput("rst_freq",  int'(FREQ_COUNT), 0);
        checkOutput("rst_state", int'(STATE), 0);
        applyStimulus(1'b0, 1'b0, 20);
        waitCycles(2);
        checkOutput("idle_state", int'(STATE), 0);

        // Nominal lock with a 40-unit ODIV2 period
        applyStimulus(1'b0, 1'b1, 20);
        waitCycles(1);
        checkOutput("en_ceb_low", int'(CEB), 0);
        checkOutput("en_startup", int'(STATE), 1);
        waitCycles(STARTUP);
        checkOutput("startup_len", int'(STATE), 2);
        waitCycles(WINDOW);
        checkOutput("first_check", int'(STATE), 3);
        checkRange("first_count", int'(FREQ_COUNT), 15, 17);
        checkOutput("check_ready", int'(READY), 0);
        waitCycles(1);
        checkOutput("lock_state", int'(STATE), 4);
        checkOutput("lock_ready", int'(READY), 1);
        waitCycles(130);
        checkOutput("steady_count", int'(FREQ_COUNT), 16);
        checkOutput("steady_ready", int'(READY), 1);

        // Lost clock while locked
        applyStimulus(1'b0, 1'b1, 0);
        waitForState(5, 200, "lost_retry");
        checkOutput("lost_ready", int'(READY), 0);
        checkOutput("lost_ceb", int'(CEB), 1);
        applyStimulus(1'b0, 1'b1, 20);
        ceb_high = 1;
        n = 0;
        while (CEB == 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
            if (CEB == 1'b1) ceb_high++;
        end
        checkOutput("retry_ceb_pulse", ceb_high, OFF);
        waitForState(4, 300, "relock");
        checkOutput("relock_ready", int'(READY), 1);

        // Slow clock: three failed attempts end in a sticky fault
        applyStimulus(1'b0, 1'b0, 40);
        waitCycles(1);
        applyStimulus(1'b0, 1'b1, 40);
        attempts = 0;
        n = 0;
        while (int'(STATE) != 6 && n < 500) begin
            @(negedge CLK);
            n++;
            if (int'(STATE) == 3) attempts++;
        end
        checkOutput("slow_fault_state", int'(STATE), 6);
        checkOutput("slow_attempts", attempts, MAX_RETRY + 1);
        checkOutput("slow_fault", int'(FAULT), 1);
        checkOutput("slow_ceb", int'(CEB), 1);
        checkRange("slow_count", int'(FREQ_COUNT), 7, 8);
        waitCycles(20);
        checkOutput("fault_sticky", int'(FAULT), 1);
        applyStimulus(1'b0, 1'b0, 20);
        waitCycles(1);
        checkOutput("fault_clear", int'(FAULT), 0);
        checkOutput("fault_off", int'(STATE), 0);
        applyStimulus(1'b0, 1'b1, 20);
        waitCycles(1);
        checkOutput("fault_restart", int'(STATE), 1);
        waitForState(4, 200, "fault_relock");

        // Fast clock: count above range, READY never rises
        applyStimulus(1'b0, 1'b0, 10);
        waitCycles(1);
        applyStimulus(1'b0, 1'b1, 10);
        ready_seen = 1'b0;
        n = 0;
        while (int'(STATE) != 6 && n < 500) begin
            @(negedge CLK);
            n++;
            if (READY == 1'b1) ready_seen = 1'b1;
        end
        checkOutput("fast_fault_state", int'(STATE), 6);
        checkOutput("fast_ready_seen", int'(ready_seen), 0);
        checkRange("fast_count", int'(FREQ_COUNT), 31, 32);

        // Abort mid-window and on the window-end cycle
        applyStimulus(1'b0, 1'b0, 20);
        waitCycles(1);
        applyStimulus(1'b0, 1'b1, 20);
        waitCycles(1 + STARTUP + 10);
        applyStimulus(1'b0, 1'b0, 20);
        waitCycles(1);
        checkOutput("abort_mid_state", int'(STATE), 0);
        checkOutput("abort_mid_ceb", int'(CEB), 1);
        checkRange("abort_mid_freq", int'(FREQ_COUNT), 31, 32);
        applyStimulus(1'b0, 1'b1, 20);
        waitCycles(1 + STARTUP);
        checkOutput("abort_measure", int'(STATE), 2);
        waitCycles(WINDOW - 1);
        applyStimulus(1'b0, 1'b0, 20);
        waitCycles(1);
        checkOutput("abort_end_state", int'(STATE), 0);
        checkOutput("abort_end_ceb", int'(CEB), 1);
        checkRange("abort_end_freq", int'(FREQ_COUNT), 31, 32);

        // Reset while locked, EN stays high
        applyStimulus(1'b0, 1'b1, 20);
        waitForState(4, 200, "pre_rst_lock");
        applyStimulus(1'b1, 1'b1, 20);
        waitCycles(1);
        checkOutput("mid_rst_ceb",   int'(CEB), 1);
        checkOutput("mid_rst_ready", int'(READY), 0);
        checkOutput("mid_rst_fault", int'(FAULT), 0);
        checkOutput("mid_rst_freq",  int'(FREQ_COUNT), 0);
        checkOutput("mid_rst_state", int'(STATE), 0);
        applyStimulus(1'b0, 1'b1, 20);
        waitCycles(1);
        checkOutput("post_rst_state", int'(STATE), 1);
        checkOutput("post_rst_ceb", int'(CEB), 0);
        waitForState(4, 200, "post_rst_lock");
        checkOutput("post_rst_ready", int'(READY), 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
